// File: rtl/fft_mag_peak.sv
// FFT result post-processor: streams |X|^2 = re^2 + im^2 per bin through a
// stallable two-stage pipeline and tracks each frame's peak bin, the number
// of completed frames and a sticky frame-length error.
module fft_mag_peak #(
    parameter int NFFT       = 3,
    parameter int COMP_WIDTH = 32,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [2*COMP_WIDTH-1:0] s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [2*COMP_WIDTH:0]   m_axis_tdata,
    input  logic                    clear,
    output logic                    peak_done,
    output logic [NFFT-1:0]         peak_index,
    output logic [2*COMP_WIDTH:0]   peak_mag,
    output logic [FCNT_WIDTH-1:0]   frame_count,
    output logic                    err_len
);
    localparam int SW = 2 * COMP_WIDTH;
    localparam int MW = 2 * COMP_WIDTH + 1;

    logic signed [COMP_WIDTH-1:0] re_in, im_in;
    logic signed [SW-1:0]         re_x, im_x;
    logic signed [SW-1:0]         sq_re, sq_im;
    logic                         v1, l1, v2, l2;
    logic [MW-1:0]                mag;
    logic                         en, hs, take, last_bin, len_err;
    logic [NFFT-1:0]              idx, run_idx, cand_idx;
    logic [MW-1:0]                run_max, cand_max;

    assign re_in = s_axis_tdata[COMP_WIDTH-1:0];
    assign im_in = s_axis_tdata[SW-1:COMP_WIDTH];
    // Sign-extend before squaring so the product is computed at full width.
    assign re_x  = SW'(re_in);
    assign im_x  = SW'(im_in);

    // Both stages move together; a full output stage blocked downstream
    // freezes the whole pipe and pushes back on the FFT core.
    assign en            = !v2 || m_axis_tready;
    assign s_axis_tready = en;
    assign m_axis_tvalid = v2;
    assign m_axis_tdata  = mag;
    assign m_axis_tlast  = l2;

    // Stage 1: signed squares of each component.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1    <= 1'b0;
            l1    <= 1'b0;
            sq_re <= '0;
            sq_im <= '0;
        end else if (en) begin
            v1    <= s_axis_tvalid;
            l1    <= s_axis_tlast;
            sq_re <= re_x * re_x;
            sq_im <= im_x * im_x;
        end
    end

    // Stage 2: sum of squares; one extra bit so (-2^31)^2 * 2 cannot overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v2  <= 1'b0;
            l2  <= 1'b0;
            mag <= '0;
        end else if (en) begin
            v2  <= v1;
            l2  <= l1;
            mag <= {1'b0, sq_re} + {1'b0, sq_im};
        end
    end

    // Peak candidate including the beat being handed off this cycle; the
    // first bin always seeds the max, later bins must be strictly larger so
    // ties stay on the lowest index.
    assign hs       = v2 && m_axis_tready;
    assign last_bin = &idx;
    assign take     = (idx == '0) || (mag > run_max);
    assign cand_max = take ? mag : run_max;
    assign cand_idx = take ? idx : run_idx;
    // tlast and the final bin index must coincide; either alone is an error.
    assign len_err  = hs && (l2 ^ last_bin);

    // Bin counter and running maximum, advanced only on output handshakes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx     <= '0;
            run_idx <= '0;
            run_max <= '0;
        end else if (hs) begin
            run_max <= cand_max;
            run_idx <= cand_idx;
            idx     <= l2 ? '0 : idx + NFFT'(1);
        end
    end

    // Frame-end results: latched peak and a single-cycle done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            peak_done  <= 1'b0;
            peak_index <= '0;
            peak_mag   <= '0;
        end else begin
            peak_done <= hs && l2;
            if (hs && l2) begin
                peak_index <= cand_idx;
                peak_mag   <= cand_max;
            end
        end
    end

    // Frame counter; clear takes priority over a coincident frame end.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_count <= '0;
        end else if (clear) begin
            frame_count <= '0;
        end else if (hs && l2) begin
            frame_count <= frame_count + FCNT_WIDTH'(1);
        end
    end

    // Sticky length error; a new error beats a coincident clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_len <= 1'b0;
        end else if (len_err) begin
            err_len <= 1'b1;
        end else if (clear) begin
            err_len <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak: hand-computed magnitudes and peaks for
// normal, tie, extreme, backpressured, mis-sized, cleared and reset frames.
module tb_fft_mag_peak;
    localparam int NFFT = 3;
    localparam int CW   = 32;
    localparam int FW   = 16;
    localparam int MW   = 2 * CW + 1;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [2*CW-1:0] s_tdata = '0;
    logic            m_tvalid, m_tready, m_tlast;
    logic [MW-1:0]   m_tdata;
    logic            clear = 1'b0;
    logic            peak_done;
    logic [NFFT-1:0] peak_index;
    logic [MW-1:0]   peak_mag;
    logic [FW-1:0]   frame_count;
    logic            err_len;

    int checks = 0;
    int failures = 0;
    int bp_mode = 0;

    logic [MW-1:0]   out_mag[$];
    logic            out_last[$];
    logic [NFFT-1:0] pk_idx[$];
    logic [MW-1:0]   pk_mag[$];
    int ready_viol = 0;
    int stab_viol = 0;

    fft_mag_peak #(.NFFT(NFFT), .COMP_WIDTH(CW), .FCNT_WIDTH(FW)) dut (
        .clk(clk), .resetn(resetn),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata),
        .clear(clear), .peak_done(peak_done), .peak_index(peak_index),
        .peak_mag(peak_mag), .frame_count(frame_count), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = low for
    // the first 5 cycles after entering the mode, then ready.
    initial begin
        int n2;
        n2 = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) begin
                m_tready = 1'b1;
                n2 = 0;
            end else if (bp_mode == 1) begin
                m_tready = !m_tready;
                n2 = 0;
            end else begin
                m_tready = (n2 >= 5);
                n2++;
            end
        end
    end

    // Output recorder: handshaken beats, peak pulses and AXIS rule violations.
    initial begin
        logic          prev_stall;
        logic [MW-1:0] prev_data;
        logic          prev_last;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (m_tvalid && m_tready) begin
                    out_mag.push_back(m_tdata);
                    out_last.push_back(m_tlast);
                end
                if (peak_done) begin
                    pk_idx.push_back(peak_index);
                    pk_mag.push_back(peak_mag);
                end
                if (m_tvalid && !m_tready && s_tready) ready_viol++;
                if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
                    stab_viol++;
                prev_stall = m_tvalid && !m_tready;
                prev_data = m_tdata;
                prev_last = m_tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Present one beat at posedge+1 and hold it until accepted.
    task automatic send_beat(input logic signed [CW-1:0] re, input logic signed [CW-1:0] im,
                             input logic last);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata = {im, re};
        s_tlast = last;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: s_tready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic run_frame(input int n, input logic signed [CW-1:0] re[8],
                             input logic signed [CW-1:0] im[8], input int last_pos);
        for (int i = 0; i < n; i++) send_beat(re[i], im[i], i == last_pos);
    endtask

    task automatic drain();
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin failures++; $display("FAIL rst_tdata: got %0h want 0", m_tdata); end
        checks++; if (peak_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", peak_done); end
        checks++; if (peak_index !== '0 || peak_mag !== '0) begin failures++; $display("FAIL rst_peak: got %0d/%0h want 0/0", peak_index, peak_mag); end
        checks++; if (frame_count !== '0 || err_len !== 1'b0) begin failures++; $display("FAIL rst_cnt: got fc=%0d err=%b want 0/0", frame_count, err_len); end
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_sready: got %b want 1", s_tready); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic signed [CW-1:0] re[8], im[8];
        logic [MW-1:0] exp_m[8];
        int ob, pb;
        re = '{1, 2, 3, 4, 0, -5, 1, 0};
        im = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_m = '{65'd1, 65'd4, 65'd9, 65'd16, 65'd0, 65'd25, 65'd1, 65'd0};
        ob = out_mag.size();
        pb = pk_idx.size();
        // Beat 0 by hand to observe the two-cycle latency.
        s_tvalid = 1'b1;
        s_tdata = {im[0], re[0]};
        @(negedge clk);
        checks++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin failures++; $display("FAIL lat_c0: got srdy=%b mvld=%b want 1/0", s_tready, m_tvalid); end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL lat_c1: got mvld=%b want 0", m_tvalid); end
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== 65'd1) begin failures++; $display("FAIL lat_c2: got mvld=%b data=%0d want 1/1", m_tvalid, m_tdata); end
        @(posedge clk);
        #1;
        for (int i = 1; i < 8; i++) send_beat(re[i], im[i], i == 7);
        drain();
        checks++; if (out_mag.size() - ob !== 8) begin failures++; $display("FAIL basic_count: got %0d beats want 8", out_mag.size() - ob); end
        for (int i = 0; i < 8 && ob + i < out_mag.size(); i++) begin
            checks++;
            if (out_mag[ob+i] !== exp_m[i] || out_last[ob+i] !== (i == 7)) begin
                failures++; $display("FAIL basic_mag%0d: got %0d last=%b want %0d last=%b", i, out_mag[ob+i], out_last[ob+i], exp_m[i], i == 7);
            end
        end
        checks++; if (pk_idx.size() - pb !== 1) begin failures++; $display("FAIL basic_done: got %0d pulses want 1", pk_idx.size() - pb); end
        checks++; if (peak_index !== 3'd5 || peak_mag !== 65'd25) begin failures++; $display("FAIL basic_peak: got %0d/%0d want 5/25", peak_index, peak_mag); end
        checks++; if (frame_count !== 16'd1 || err_len !== 1'b0) begin failures++; $display("FAIL basic_cnt: got fc=%0d err=%b want 1/0", frame_count, err_len); end
    endtask

    task automatic test_tie_and_extreme();
        logic signed [CW-1:0] re[8], im[8];
        logic [MW-1:0] big;
        int ob;
        big = 65'd1 << 63;
        re = '{0, 0, 3, 0, 0, 0, 3, 0};
        im = '{0, 0, 0, 0, -2, 0, 0, 0};
        run_frame(8, re, im, 7);
        drain();
        checks++; if (peak_index !== 3'd2 || peak_mag !== 65'd9) begin failures++; $display("FAIL tie_peak: got %0d/%0d want 2/9", peak_index, peak_mag); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL tie_cnt: got %0d want 2", frame_count); end
        re = '{-1, 0, 0, 32'sh80000000, 0, 0, 0, 0};
        im = '{0, 0, 0, 32'sh80000000, 0, 0, 0, 0};
        ob = out_mag.size();
        run_frame(8, re, im, 7);
        drain();
        checks++; if (ob + 3 >= out_mag.size() || out_mag[ob+3] !== big) begin failures++; $display("FAIL big_mag: got %0h want %0h", (ob + 3 < out_mag.size()) ? out_mag[ob+3] : '0, big); end
        checks++; if (peak_index !== 3'd3 || peak_mag !== big) begin failures++; $display("FAIL big_peak: got %0d/%0h want 3/%0h", peak_index, peak_mag, big); end
        checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL big_cnt: got %0d want 3", frame_count); end
    endtask

    task automatic test_backpressure();
        logic signed [CW-1:0] re[8], im[8];
        logic [MW-1:0] exp_m[8];
        int ob, pb, rv, sv;
        re = '{1, 2, 3, 4, 0, -5, 1, 0};
        im = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_m = '{65'd1, 65'd4, 65'd9, 65'd16, 65'd0, 65'd25, 65'd1, 65'd0};
        rv = ready_viol;
        sv = stab_viol;
        for (int m = 1; m <= 2; m++) begin
            ob = out_mag.size();
            pb = pk_idx.size();
            bp_mode = m;
            run_frame(8, re, im, 7);
            drain();
            bp_mode = 0;
            checks++; if (out_mag.size() - ob !== 8) begin failures++; $display("FAIL bp%0d_count: got %0d beats want 8", m, out_mag.size() - ob); end
            for (int i = 0; i < 8 && ob + i < out_mag.size(); i++) begin
                checks++;
                if (out_mag[ob+i] !== exp_m[i]) begin failures++; $display("FAIL bp%0d_mag%0d: got %0d want %0d", m, i, out_mag[ob+i], exp_m[i]); end
            end
            checks++; if (pk_idx.size() - pb !== 1 || peak_index !== 3'd5 || peak_mag !== 65'd25) begin failures++; $display("FAIL bp%0d_peak: got pulses=%0d %0d/%0d want 1 5/25", m, pk_idx.size() - pb, peak_index, peak_mag); end
        end
        checks++; if (frame_count !== 16'd5) begin failures++; $display("FAIL bp_cnt: got %0d want 5", frame_count); end
        checks++; if (ready_viol - rv !== 0) begin failures++; $display("FAIL bp_sready: got %0d stalled cycles with s_tready=1 want 0", ready_viol - rv); end
        checks++; if (stab_viol - sv !== 0) begin failures++; $display("FAIL bp_stable: got %0d unstable stalled beats want 0", stab_viol - sv); end
    endtask

    task automatic test_short_frame();
        logic signed [CW-1:0] re[8], im[8];
        int ob;
        re = '{1, 2, 3, 4, 0, -5, 1, 0};
        im = '{0, 0, 0, 0, 0, 0, 0, 0};
        ob = out_mag.size();
        run_frame(6, re, im, 5);
        drain();
        checks++; if (out_mag.size() - ob !== 6 || out_last[out_mag.size()-1] !== 1'b1) begin failures++; $display("FAIL short_count: got %0d beats want 6 ending in tlast", out_mag.size() - ob); end
        checks++; if (err_len !== 1'b1 || frame_count !== 16'd6) begin failures++; $display("FAIL short_err: got err=%b fc=%0d want 1/6", err_len, frame_count); end
        checks++; if (peak_index !== 3'd5 || peak_mag !== 65'd25) begin failures++; $display("FAIL short_peak: got %0d/%0d want 5/25", peak_index, peak_mag); end
        re = '{0, 0, 0, 0, 0, 0, 0, 7};
        run_frame(8, re, im, 7);
        drain();
        checks++; if (peak_index !== 3'd7 || peak_mag !== 65'd49 || frame_count !== 16'd7) begin failures++; $display("FAIL short_next: got %0d/%0d fc=%0d want 7/49 fc=7", peak_index, peak_mag, frame_count); end
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL short_sticky: got %b want 1", err_len); end
        pulse_clear();
        checks++; if (err_len !== 1'b0 || frame_count !== 16'd0) begin failures++; $display("FAIL clear: got err=%b fc=%0d want 0/0", err_len, frame_count); end
        checks++; if (peak_index !== 3'd7 || peak_mag !== 65'd49) begin failures++; $display("FAIL clear_peak: got %0d/%0d want 7/49", peak_index, peak_mag); end
    endtask

    task automatic test_missing_tlast();
        logic signed [CW-1:0] re[8], re2[8], im[8];
        int pb;
        re  = '{0, 9, 0, 0, 0, 0, 0, 0};
        re2 = '{1, 2, 3, 4, 0, -5, 1, 0};
        im  = '{0, 0, 0, 0, 0, 0, 0, 0};
        pb = pk_idx.size();
        run_frame(8, re, im, -1);
        run_frame(8, re2, im, 7);
        drain();
        checks++; if (pk_idx.size() - pb !== 1) begin failures++; $display("FAIL miss_done: got %0d pulses want 1", pk_idx.size() - pb); end
        checks++; if (peak_index !== 3'd5 || peak_mag !== 65'd25) begin failures++; $display("FAIL miss_peak: got %0d/%0d want 5/25", peak_index, peak_mag); end
        checks++; if (err_len !== 1'b1 || frame_count !== 16'd1) begin failures++; $display("FAIL miss_cnt: got err=%b fc=%0d want 1/1", err_len, frame_count); end
    endtask

    task automatic test_clear_collisions();
        logic signed [CW-1:0] re[8], im[8];
        int pb;
        re = '{1, 2, 3, 4, 0, -5, 1, 0};
        im = '{0, 0, 0, 0, 0, 0, 0, 0};
        pulse_clear();
        checks++; if (err_len !== 1'b0 || frame_count !== 16'd0) begin failures++; $display("FAIL cc_pre: got err=%b fc=%0d want 0/0", err_len, frame_count); end
        run_frame(7, re, im, -1);
        drain();
        pb = pk_idx.size();
        // Last beat handshakes at the second posedge after acceptance.
        send_beat(re[7], im[7], 1'b1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        drain();
        checks++; if (pk_idx.size() - pb !== 1) begin failures++; $display("FAIL cc_done: got %0d pulses want 1", pk_idx.size() - pb); end
        checks++; if (frame_count !== 16'd0 || peak_index !== 3'd5 || peak_mag !== 65'd25) begin failures++; $display("FAIL cc_frame: got fc=%0d %0d/%0d want 0 5/25", frame_count, peak_index, peak_mag); end
        run_frame(5, re, im, -1);
        drain();
        send_beat(re[5], im[5], 1'b1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        drain();
        checks++; if (err_len !== 1'b1 || frame_count !== 16'd0) begin failures++; $display("FAIL cc_err: got err=%b fc=%0d want 1/0", err_len, frame_count); end
    endtask

    task automatic test_reset_mid_frame();
        logic signed [CW-1:0] re[8], im[8];
        int pb;
        re = '{1, 2, 3, 4, 0, -5, 1, 0};
        im = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_frame(4, re, im, -1);
        resetn = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0) begin failures++; $display("FAIL mrst_out: got vld=%b data=%0d want 0/0", m_tvalid, m_tdata); end
        checks++; if (peak_index !== '0 || peak_mag !== '0 || frame_count !== '0 || err_len !== 1'b0) begin failures++; $display("FAIL mrst_state: got %0d/%0d fc=%0d err=%b want all 0", peak_index, peak_mag, frame_count, err_len); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        pb = pk_idx.size();
        run_frame(8, re, im, 7);
        drain();
        checks++; if (pk_idx.size() - pb !== 1 || peak_index !== 3'd5 || peak_mag !== 65'd25) begin failures++; $display("FAIL mrst_peak: got pulses=%0d %0d/%0d want 1 5/25", pk_idx.size() - pb, peak_index, peak_mag); end
        checks++; if (frame_count !== 16'd1 || err_len !== 1'b0) begin failures++; $display("FAIL mrst_cnt: got fc=%0d err=%b want 1/0", frame_count, err_len); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_and_extreme();
        test_backpressure();
        test_short_frame();
        test_missing_tlast();
        test_clear_collisions();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
